// File: rtl/cp0_pkg.sv
// Shared CP0 encodings: operation codes, register addresses and field positions.
package cp0_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned EXC_W = 5;
    localparam int unsigned ID_W  = 3;
    localparam int unsigned ADR_W = 5;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_STORE = 2'b01,
        OP_ERET  = 2'b10,
        OP_RSVD  = 2'b11
    } cp0_op_e;

    localparam logic [ADR_W-1:0] CP0_STATUS = 5'd12;
    localparam logic [ADR_W-1:0] CP0_CAUSE  = 5'd13;
    localparam logic [ADR_W-1:0] CP0_EPCR   = 5'd14;
    localparam logic [ADR_W-1:0] CP0_EHBR   = 5'd15;

    localparam int unsigned IE_BIT  = 0;
    localparam int unsigned EXL_BIT = 1;
    localparam int unsigned EXC_LSB = 2;
    localparam int unsigned IM_LSB  = 8;
    localparam int unsigned IP_LSB  = 8;

endpackage

// File: rtl/cp0_irq_arb.sv
// Interrupt edge capture and fixed-priority (lowest index wins) arbitration.
module cp0_irq_arb
    import cp0_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] ip,
    input  logic [NUM_IRQ-1:0] im,
    output logic [NUM_IRQ-1:0] rise_c,
    output logic               any_valid_c,
    output logic [ID_W-1:0]    id_c
);

    logic [NUM_IRQ-1:0] irq_prev_q;
    logic [NUM_IRQ-1:0] irq_prev_d;
    logic [NUM_IRQ-1:0] pend_c;

    // Previous line levels for 0->1 detection.
    always_comb begin
        irq_prev_d = irq_in;
    end

    // Edge history register.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_prev_q <= '0;
        end else begin
            irq_prev_q <= irq_prev_d;
        end
    end

    // Rising edges, masked pending set and lowest-index winner.
    always_comb begin
        rise_c      = irq_in & ~irq_prev_q;
        pend_c      = ip & im;
        any_valid_c = |pend_c;
        id_c        = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (pend_c[i]) begin
                id_c = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/cp0_intc.sv
// CP0 register file with vectored multi-source interrupt entry and ERET redirect.
module cp0_intc
    import cp0_pkg::*;
#(
    parameter int unsigned NUM_IRQ    = 4,
    parameter int unsigned VEC_SHIFT  = 4,
    parameter logic [31:0] RESET_EHBR = 32'h0000_0008
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         oper,
    input  logic [ADR_W-1:0]   addr_r,
    output logic [XLEN-1:0]    data_r,
    input  logic [ADR_W-1:0]   addr_w,
    input  logic [XLEN-1:0]    data_w,
    input  logic               ir_en,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [XLEN-1:0]    ret_addr,
    output logic               jump_en,
    output logic [XLEN-1:0]    jump_addr,
    output logic [ID_W-1:0]    irq_id
);

    logic               ie_q, ie_d;
    logic               exl_q, exl_d;
    logic [NUM_IRQ-1:0] im_q, im_d;
    logic [NUM_IRQ-1:0] ip_q, ip_d;
    logic [EXC_W-1:0]   exc_q, exc_d;
    logic [XLEN-1:0]    epc_q, epc_d;
    logic [XLEN-1:0]    ehbr_q, ehbr_d;
    logic               jump_en_q, jump_en_d;
    logic [XLEN-1:0]    jump_addr_q, jump_addr_d;

    logic               store_c;
    logic               eret_c;
    logic               take_c;
    logic [NUM_IRQ-1:0] rise_c;
    logic               any_valid_c;
    logic [ID_W-1:0]    id_c;
    logic [NUM_IRQ-1:0] w1c_c;
    logic [NUM_IRQ-1:0] eret_clr_c;
    logic [XLEN-1:0]    vec_c;
    logic               unused_data_w_c;

    cp0_irq_arb #(
        .NUM_IRQ (NUM_IRQ)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .irq_in      (irq_in),
        .ip          (ip_q),
        .im          (im_q),
        .rise_c      (rise_c),
        .any_valid_c (any_valid_c),
        .id_c        (id_c)
    );

    // Only a few data_w bits map to architectural fields.
    assign unused_data_w_c = ^data_w;

    // Decode, take decision and vector. A take is held off while a redirect
    // pulse is out so every pulse is followed by at least one low cycle.
    always_comb begin
        store_c    = (oper == OP_STORE);
        eret_c     = (oper == OP_ERET);
        take_c     = ir_en & ie_q & ~exl_q & any_valid_c & ~eret_c & ~jump_en_q;
        vec_c      = ehbr_q + (XLEN'(id_c) << VEC_SHIFT);
        eret_clr_c = eret_c ? (NUM_IRQ'(1) << exc_q[2:0]) : '0;
    end

    // Next state: software store first, then hardware entry/return overrides.
    always_comb begin
        ie_d        = ie_q;
        exl_d       = exl_q;
        im_d        = im_q;
        exc_d       = exc_q;
        epc_d       = epc_q;
        ehbr_d      = ehbr_q;
        jump_en_d   = 1'b0;
        jump_addr_d = jump_addr_q;
        w1c_c       = '0;

        if (store_c) begin
            case (addr_w)
                CP0_STATUS: begin
                    ie_d  = data_w[IE_BIT];
                    exl_d = data_w[EXL_BIT];
                    im_d  = data_w[IM_LSB +: NUM_IRQ];
                end
                CP0_CAUSE: w1c_c  = data_w[IP_LSB +: NUM_IRQ];
                CP0_EPCR:  epc_d  = data_w;
                CP0_EHBR:  ehbr_d = data_w;
                default: ;
            endcase
        end

        // A new edge wins over any clear of the same bit.
        ip_d = (ip_q & ~w1c_c & ~eret_clr_c) | rise_c;

        if (take_c) begin
            epc_d       = ret_addr;
            exl_d       = 1'b1;
            exc_d       = EXC_W'(id_c);
            jump_en_d   = 1'b1;
            jump_addr_d = vec_c;
        end

        if (eret_c) begin
            exl_d       = 1'b0;
            jump_en_d   = 1'b1;
            jump_addr_d = epc_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ie_q        <= 1'b0;
            exl_q       <= 1'b0;
            im_q        <= '0;
            ip_q        <= '0;
            exc_q       <= '0;
            epc_q       <= '0;
            ehbr_q      <= RESET_EHBR;
            jump_en_q   <= 1'b0;
            jump_addr_q <= '0;
        end else begin
            ie_q        <= ie_d;
            exl_q       <= exl_d;
            im_q        <= im_d;
            ip_q        <= ip_d;
            exc_q       <= exc_d;
            epc_q       <= epc_d;
            ehbr_q      <= ehbr_d;
            jump_en_q   <= jump_en_d;
            jump_addr_q <= jump_addr_d;
        end
    end

    // Combinational register read port.
    always_comb begin
        data_r = '0;
        case (addr_r)
            CP0_STATUS: begin
                data_r[IE_BIT]              = ie_q;
                data_r[EXL_BIT]             = exl_q;
                data_r[IM_LSB +: NUM_IRQ]   = im_q;
            end
            CP0_CAUSE: begin
                data_r[EXC_LSB +: EXC_W]    = exc_q;
                data_r[IP_LSB +: NUM_IRQ]   = ip_q;
            end
            CP0_EPCR: data_r = epc_q;
            CP0_EHBR: data_r = ehbr_q;
            default: ;
        endcase
    end

    assign jump_en   = jump_en_q;
    assign jump_addr = jump_addr_q;
    assign irq_id    = exc_q[2:0];

endmodule

// File: tb/tb_cp0_intc.sv
// Self-checking bench for cp0_intc with a redirect scoreboard.
module tb_cp0_intc;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  id;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [1:0]  oper;
    logic [4:0]  addr_r;
    logic [31:0] data_r;
    logic [4:0]  addr_w;
    logic [31:0] data_w;
    logic        ir_en;
    logic [3:0]  irq_in;
    logic [31:0] ret_addr;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic [2:0]  irq_id;

    int   checks;
    int   failures;
    exp_t sb[$];

    cp0_intc #(
        .NUM_IRQ    (4),
        .VEC_SHIFT  (4),
        .RESET_EHBR (32'h0000_0008)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .oper      (oper),
        .addr_r    (addr_r),
        .data_r    (data_r),
        .addr_w    (addr_w),
        .data_w    (data_w),
        .ir_en     (ir_en),
        .irq_in    (irq_in),
        .ret_addr  (ret_addr),
        .jump_en   (jump_en),
        .jump_addr (jump_addr),
        .irq_id    (irq_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [4:0] a, input logic [31:0] d);
        oper   = 2'b01;
        addr_w = a;
        data_w = d;
        tick();
        oper   = 2'b00;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        addr_r = a;
        #1;
        d = data_r;
    endtask

    task automatic pop_exp(output exp_t e, output bit have);
        have = (sb.size() != 0);
        e.addr = 32'hdead_beef;
        e.id   = 3'd7;
        if (have) e = sb.pop_front();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        rd(5'd12, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL reset_status got=%h exp=0", d); end
        rd(5'd13, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL reset_cause got=%h exp=0", d); end
        rd(5'd14, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL reset_epc got=%h exp=0", d); end
        rd(5'd15, d); checks++;
        if (d !== 32'h8) begin failures++; $display("FAIL reset_ehbr got=%h exp=8", d); end
        checks++;
        if (jump_en !== 1'b0 || jump_addr !== 32'h0 || irq_id !== 3'd0) begin
            failures++;
            $display("FAIL reset_outputs got en=%b addr=%h id=%0d exp en=0 addr=0 id=0", jump_en, jump_addr, irq_id);
        end
    endtask

    task automatic test_basic_take();
        logic [31:0] d;
        exp_t e;
        bit   have;
        store(5'd12, 32'h0000_0F01);
        rd(5'd12, d); checks++;
        if (d !== 32'h0F01) begin failures++; $display("FAIL status_write got=%h exp=00000f01", d); end
        irq_in = 4'b0100;
        sb.push_back('{addr: 32'h28, id: 3'd2});
        tick();
        irq_in = 4'b0000;
        tick();
        pop_exp(e, have); checks++;
        if (jump_en !== 1'b1 || !have || jump_addr !== e.addr || irq_id !== e.id) begin
            failures++;
            $display("FAIL take_irq2 got en=%b addr=%h id=%0d exp en=1 addr=%h id=%0d", jump_en, jump_addr, irq_id, e.addr, e.id);
        end
        rd(5'd14, d); checks++;
        if (d !== 32'h40) begin failures++; $display("FAIL take_epc got=%h exp=40", d); end
        rd(5'd12, d); checks++;
        if (d !== 32'h0F03) begin failures++; $display("FAIL take_exl got=%h exp=00000f03", d); end
        tick();
        checks++;
        if (jump_en !== 1'b0 || jump_addr !== 32'h28) begin
            failures++;
            $display("FAIL pulse_width got en=%b addr=%h exp en=0 addr=28", jump_en, jump_addr);
        end
        oper = 2'b10;
        sb.push_back('{addr: 32'h40, id: 3'd2});
        tick();
        oper = 2'b00;
        pop_exp(e, have); checks++;
        if (jump_en !== 1'b1 || !have || jump_addr !== e.addr || irq_id !== e.id) begin
            failures++;
            $display("FAIL eret1 got en=%b addr=%h id=%0d exp en=1 addr=%h id=%0d", jump_en, jump_addr, irq_id, e.addr, e.id);
        end
        rd(5'd13, d); checks++;
        if (d !== 32'h0000_0008) begin failures++; $display("FAIL eret1_cause got=%h exp=00000008", d); end
        tick();
    endtask

    task automatic test_priority();
        logic [31:0] d;
        exp_t e;
        bit   have;
        irq_in = 4'b1010;
        sb.push_back('{addr: 32'h18, id: 3'd1});
        tick();
        irq_in = 4'b0000;
        tick();
        pop_exp(e, have); checks++;
        if (jump_en !== 1'b1 || !have || jump_addr !== e.addr || irq_id !== e.id) begin
            failures++;
            $display("FAIL prio_irq1 got en=%b addr=%h id=%0d exp en=1 addr=%h id=%0d", jump_en, jump_addr, irq_id, e.addr, e.id);
        end
        tick();
        oper = 2'b10;
        sb.push_back('{addr: 32'h40, id: 3'd1});
        sb.push_back('{addr: 32'h38, id: 3'd3});
        tick();
        oper = 2'b00;
        pop_exp(e, have); checks++;
        if (jump_en !== 1'b1 || !have || jump_addr !== e.addr || irq_id !== e.id) begin
            failures++;
            $display("FAIL prio_eret got en=%b addr=%h id=%0d exp en=1 addr=%h id=%0d", jump_en, jump_addr, irq_id, e.addr, e.id);
        end
        rd(5'd13, d); checks++;
        if (d !== 32'h0000_0804) begin failures++; $display("FAIL prio_ip1_clear got=%h exp=00000804", d); end
        tick();
        checks++;
        if (jump_en !== 1'b0) begin failures++; $display("FAIL idle_after_eret got en=%b exp=0", jump_en); end
        tick();
        pop_exp(e, have); checks++;
        if (jump_en !== 1'b1 || !have || jump_addr !== e.addr || irq_id !== e.id) begin
            failures++;
            $display("FAIL prio_irq3 got en=%b addr=%h id=%0d exp en=1 addr=%h id=%0d", jump_en, jump_addr, irq_id, e.addr, e.id);
        end
        tick();
        oper = 2'b10;
        sb.push_back('{addr: 32'h40, id: 3'd3});
        tick();
        oper = 2'b00;
        pop_exp(e, have); checks++;
        if (jump_en !== 1'b1 || !have || jump_addr !== e.addr || irq_id !== e.id) begin
            failures++;
            $display("FAIL prio_eret3 got en=%b addr=%h id=%0d exp en=1 addr=%h id=%0d", jump_en, jump_addr, irq_id, e.addr, e.id);
        end
        tick();
    endtask

    task automatic test_mask();
        logic [31:0] d;
        exp_t e;
        bit   have;
        store(5'd12, 32'h0000_0B01);
        irq_in = 4'b0100;
        tick();
        irq_in = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (jump_en !== 1'b0) begin failures++; $display("FAIL masked_no_jump cyc=%0d got en=%b exp=0", i, jump_en); end
        end
        rd(5'd13, d); checks++;
        if (d !== 32'h0000_040C) begin failures++; $display("FAIL masked_ip got=%h exp=0000040c", d); end
        sb.push_back('{addr: 32'h28, id: 3'd2});
        store(5'd12, 32'h0000_0F01);
        checks++;
        if (jump_en !== 1'b0) begin failures++; $display("FAIL unmask_early got en=%b exp=0", jump_en); end
        tick();
        pop_exp(e, have); checks++;
        if (jump_en !== 1'b1 || !have || jump_addr !== e.addr || irq_id !== e.id) begin
            failures++;
            $display("FAIL unmask_take got en=%b addr=%h id=%0d exp en=1 addr=%h id=%0d", jump_en, jump_addr, irq_id, e.addr, e.id);
        end
        tick();
        oper = 2'b10;
        sb.push_back('{addr: 32'h40, id: 3'd2});
        tick();
        oper = 2'b00;
        pop_exp(e, have); checks++;
        if (jump_en !== 1'b1 || !have || jump_addr !== e.addr || irq_id !== e.id) begin
            failures++;
            $display("FAIL mask_eret got en=%b addr=%h id=%0d exp en=1 addr=%h id=%0d", jump_en, jump_addr, irq_id, e.addr, e.id);
        end
        tick();
    endtask

    task automatic test_exl_block();
        exp_t e;
        bit   have;
        store(5'd12, 32'h0000_0F03);
        irq_in = 4'b0001;
        tick();
        irq_in = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (jump_en !== 1'b0) begin failures++; $display("FAIL exl_block cyc=%0d got en=%b exp=0", i, jump_en); end
        end
        oper = 2'b10;
        sb.push_back('{addr: 32'h40, id: 3'd2});
        sb.push_back('{addr: 32'h08, id: 3'd0});
        tick();
        oper = 2'b00;
        pop_exp(e, have); checks++;
        if (jump_en !== 1'b1 || !have || jump_addr !== e.addr || irq_id !== e.id) begin
            failures++;
            $display("FAIL exl_eret got en=%b addr=%h id=%0d exp en=1 addr=%h id=%0d", jump_en, jump_addr, irq_id, e.addr, e.id);
        end
        tick();
        checks++;
        if (jump_en !== 1'b0) begin failures++; $display("FAIL exl_idle got en=%b exp=0", jump_en); end
        tick();
        pop_exp(e, have); checks++;
        if (jump_en !== 1'b1 || !have || jump_addr !== e.addr || irq_id !== e.id) begin
            failures++;
            $display("FAIL exl_irq0 got en=%b addr=%h id=%0d exp en=1 addr=%h id=%0d", jump_en, jump_addr, irq_id, e.addr, e.id);
        end
        tick();
        oper = 2'b10;
        sb.push_back('{addr: 32'h40, id: 3'd0});
        tick();
        oper = 2'b00;
        pop_exp(e, have); checks++;
        if (jump_en !== 1'b1 || !have || jump_addr !== e.addr || irq_id !== e.id) begin
            failures++;
            $display("FAIL exl_eret0 got en=%b addr=%h id=%0d exp en=1 addr=%h id=%0d", jump_en, jump_addr, irq_id, e.addr, e.id);
        end
        tick();
    endtask

    task automatic test_store_take();
        logic [31:0] d;
        exp_t e;
        bit   have;
        ret_addr = 32'h80;
        irq_in   = 4'b0010;
        sb.push_back('{addr: 32'h18, id: 3'd1});
        tick();
        irq_in = 4'b0000;
        store(5'd14, 32'h0000_1234);
        pop_exp(e, have); checks++;
        if (jump_en !== 1'b1 || !have || jump_addr !== e.addr || irq_id !== e.id) begin
            failures++;
            $display("FAIL st_take got en=%b addr=%h id=%0d exp en=1 addr=%h id=%0d", jump_en, jump_addr, irq_id, e.addr, e.id);
        end
        rd(5'd14, d); checks++;
        if (d !== 32'h80) begin failures++; $display("FAIL st_take_epc got=%h exp=80", d); end
        tick();
        oper = 2'b10;
        sb.push_back('{addr: 32'h80, id: 3'd1});
        tick();
        oper = 2'b00;
        pop_exp(e, have); checks++;
        if (jump_en !== 1'b1 || !have || jump_addr !== e.addr || irq_id !== e.id) begin
            failures++;
            $display("FAIL st_eret got en=%b addr=%h id=%0d exp en=1 addr=%h id=%0d", jump_en, jump_addr, irq_id, e.addr, e.id);
        end
        tick();
    endtask

    task automatic test_w1c();
        logic [31:0] d;
        store(5'd12, 32'h0000_0F00);
        irq_in = 4'b0010;
        tick();
        irq_in = 4'b0000;
        tick();
        rd(5'd13, d); checks++;
        if (d !== 32'h0000_0204) begin failures++; $display("FAIL w1c_pre got=%h exp=00000204", d); end
        irq_in = 4'b0010;
        store(5'd13, 32'h0000_0200);
        rd(5'd13, d); checks++;
        if (d !== 32'h0000_0204) begin failures++; $display("FAIL w1c_vs_edge got=%h exp=00000204", d); end
        store(5'd13, 32'hFFFF_FFFF);
        rd(5'd13, d); checks++;
        if (d !== 32'h0000_0004) begin failures++; $display("FAIL w1c_clear got=%h exp=00000004", d); end
        irq_in = 4'b0000;
        tick();
        checks++;
        if (jump_en !== 1'b0) begin failures++; $display("FAIL ie_off_no_jump got en=%b exp=0", jump_en); end
        store(5'd3, 32'hFFFF_FFFF);
        rd(5'd3, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL unmapped got=%h exp=0", d); end
    endtask

    task automatic test_reset_in_pulse();
        logic [31:0] d;
        exp_t e;
        bit   have;
        store(5'd15, 32'h0000_1000);
        store(5'd12, 32'h0000_0F01);
        irq_in = 4'b0100;
        sb.push_back('{addr: 32'h1020, id: 3'd2});
        tick();
        irq_in = 4'b0000;
        tick();
        pop_exp(e, have); checks++;
        if (jump_en !== 1'b1 || !have || jump_addr !== e.addr || irq_id !== e.id) begin
            failures++;
            $display("FAIL ehbr_take got en=%b addr=%h id=%0d exp en=1 addr=%h id=%0d", jump_en, jump_addr, irq_id, e.addr, e.id);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (jump_en !== 1'b0 || jump_addr !== 32'h0 || irq_id !== 3'd0) begin
            failures++;
            $display("FAIL rst_pulse got en=%b addr=%h id=%0d exp en=0 addr=0 id=0", jump_en, jump_addr, irq_id);
        end
        rd(5'd12, d); checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL rst_status got=%h exp=0", d); end
        rd(5'd15, d); checks++;
        if (d !== 32'h8) begin failures++; $display("FAIL rst_ehbr got=%h exp=8", d); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        oper     = 2'b00;
        addr_r   = 5'd0;
        addr_w   = 5'd0;
        data_w   = 32'h0;
        ir_en    = 1'b1;
        irq_in   = 4'b0000;
        ret_addr = 32'h40;
        test_reset();
        test_basic_take();
        test_priority();
        test_mask();
        test_exl_block();
        test_store_take();
        test_w1c();
        test_reset_in_pulse();
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL sb_drain left=%0d exp=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
